// File: rtl/video_line_prefetcher_if.sv
// Pixel-request and SDRAM read-burst signals of the video line prefetcher, grouped.
// slave = prefetcher side, master = display/arbiter side.
interface video_line_prefetcher_if #(
    parameter int ADDR_W = 20
);
    logic              iFrame_Start;
    logic              iRead_En;
    logic [9:0]        iRead_X;
    logic [9:0]        iRead_Y;
    logic [9:0]        oVideo_R;
    logic [9:0]        oVideo_G;
    logic [9:0]        oVideo_B;
    logic              oMem_Req;
    logic [ADDR_W-1:0] oMem_Addr;
    logic              iMem_Ack;
    logic              iMem_Valid;
    logic [29:0]       iMem_Data;
    logic              oUnderrun;

    modport slave (
        input  iFrame_Start, iRead_En, iRead_X, iRead_Y, iMem_Ack, iMem_Valid, iMem_Data,
        output oVideo_R, oVideo_G, oVideo_B, oMem_Req, oMem_Addr, oUnderrun
    );

    modport master (
        output iFrame_Start, iRead_En, iRead_X, iRead_Y, iMem_Ack, iMem_Valid, iMem_Data,
        input  oVideo_R, oVideo_G, oVideo_B, oMem_Req, oMem_Addr, oUnderrun
    );
endinterface

// File: rtl/video_line_prefetcher.sv
// Double-buffered display-line prefetcher: pixels out 1 cycle after request; one SDRAM burst outstanding,
// request held until iMem_Ack. READER_TEST_PATTERN_EN replaces memory data with 8 colour bars.
module video_line_prefetcher #(
    parameter int H_PIXELS  = 640,
    parameter int V_LINES   = 380,
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 20,
    parameter int BASE_ADDR = 0
) (
    input logic iCLK,
    input logic iRST,
    video_line_prefetcher_if.slave bus
);
    localparam int N_BURSTS = H_PIXELS / BURST_LEN;
    localparam int XW = $clog2(H_PIXELS);
    localparam int BW = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;
    localparam int WW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [WW-1:0]     word_q, word_d;
    logic [9:0]        fill_line_q, fill_line_d;
    logic              pend_q, pend_d;
    logic [9:0]        pend_line_q, pend_line_d;
    logic              ready_q, ready_d;
    logic              fill_bank_q, fill_bank_d;
    logic              disp_bank_q, disp_bank_d;
    logic [9:0]        last_y_q, last_y_d;
    logic              underrun_q, underrun_d;
    logic [29:0]       pix_q, pix_d;

    logic          new_line, line_ok, abort, last_word, wr_en;
    logic [XW-1:0] wr_idx;
    logic [29:0]   line_mem [2][H_PIXELS];

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [9:0] line, input logic [BW-1:0] b);
        logic [31:0] a;
        a = 32'(BASE_ADDR) + 32'(line) * 32'(H_PIXELS) + 32'(b) * 32'(BURST_LEN);
        return a[ADDR_W-1:0];
    endfunction

    assign wr_idx = XW'(int'(burst_q) * BURST_LEN + int'(word_q));

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        word_d      = word_q;
        fill_line_d = fill_line_q;
        pend_d      = pend_q;
        pend_line_d = pend_line_q;
        ready_d     = ready_q;
        fill_bank_d = fill_bank_q;
        disp_bank_d = disp_bank_q;
        last_y_d    = last_y_q;
        underrun_d  = underrun_q;
        wr_en       = 1'b0;
        new_line    = bus.iRead_En && (bus.iRead_X == '0) && (bus.iRead_Y != last_y_q);
        line_ok     = ready_q && (fill_line_q == bus.iRead_Y);
        abort       = bus.iFrame_Start || (new_line && !line_ok);
        last_word   = (word_q == WW'(BURST_LEN - 1));

        unique case (state_q)
            IDLE: if (pend_q) begin
                state_d     = REQ;
                req_d       = 1'b1;
                addr_d      = burst_addr(pend_line_q, '0);
                fill_line_d = pend_line_q;
                burst_d     = '0;
                pend_d      = 1'b0;
            end
            REQ: if (bus.iMem_Ack) begin
                state_d = DATA;
                req_d   = 1'b0;
                word_d  = '0;
            end
            DATA: if (bus.iMem_Valid) begin
                wr_en  = 1'b1;
                word_d = word_q + WW'(1);
                if (last_word) begin
                    word_d = '0;
                    if (burst_q == BW'(N_BURSTS - 1)) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        burst_d = burst_q + BW'(1);
                        addr_d  = burst_addr(fill_line_q, burst_q + BW'(1));
                    end
                end
            end
            DRAIN: if (bus.iMem_Valid) begin
                word_d = word_q + WW'(1);
                if (last_word) begin
                    word_d  = '0;
                    state_d = IDLE;
                end
            end
        endcase

        // An accepted burst must still be drained; an unaccepted request is simply withdrawn.
        if (abort) begin
            ready_d = 1'b0;
            req_d   = 1'b0;
            unique case (state_q)
                IDLE:  state_d = IDLE;
                REQ: begin
                    state_d = bus.iMem_Ack ? DRAIN : IDLE;
                    word_d  = '0;
                end
                DATA: begin
                    wr_en   = 1'b0;
                    state_d = (bus.iMem_Valid && last_word) ? IDLE : DRAIN;
                end
                DRAIN: state_d = DRAIN;
            endcase
        end

        if (bus.iFrame_Start) begin
            fill_bank_d = 1'b0;
            pend_d      = 1'b1;
            pend_line_d = '0;
        end else if (new_line) begin
            disp_bank_d = fill_bank_q;
            fill_bank_d = ~fill_bank_q;
            last_y_d    = bus.iRead_Y;
            ready_d     = 1'b0;
            if (!line_ok) underrun_d = 1'b1;
            if (int'(bus.iRead_Y) < V_LINES - 1) begin
                pend_d      = 1'b1;
                pend_line_d = bus.iRead_Y + 10'd1;
            end else begin
                pend_d = 1'b0;
            end
        end
    end

`ifdef READER_TEST_PATTERN_EN
    logic [2:0] bar;
    always_comb begin
        bar   = 3'(int'(bus.iRead_X) / (H_PIXELS / 8));
        pix_d = '0;
        if (bus.iRead_En) pix_d = {{10{bar[2]}}, {10{bar[1]}}, {10{bar[0]}}};
    end
    assign bus.oMem_Req  = 1'b0;
    assign bus.oMem_Addr = '0;
    assign bus.oUnderrun = 1'b0;
`else
    // Read through the post-swap bank so pixel 0 of a new line comes from the fresh line.
    always_comb begin
        pix_d = '0;
        if (bus.iRead_En && int'(bus.iRead_X) < H_PIXELS) pix_d = line_mem[disp_bank_d][XW'(bus.iRead_X)];
    end
    assign bus.oMem_Req  = req_q;
    assign bus.oMem_Addr = addr_q;
    assign bus.oUnderrun = underrun_q;
`endif

    assign bus.oVideo_R = pix_q[29:20];
    assign bus.oVideo_G = pix_q[19:10];
    assign bus.oVideo_B = pix_q[9:0];

    always_ff @(posedge iCLK) begin
        if (wr_en) line_mem[fill_bank_q][wr_idx] <= bus.iMem_Data;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            burst_q     <= '0;
            word_q      <= '0;
            fill_line_q <= '0;
            pend_q      <= 1'b0;
            pend_line_q <= '0;
            ready_q     <= 1'b0;
            fill_bank_q <= 1'b0;
            disp_bank_q <= 1'b0;
            last_y_q    <= '1;
            underrun_q  <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            word_q      <= word_d;
            fill_line_q <= fill_line_d;
            pend_q      <= pend_d;
            pend_line_q <= pend_line_d;
            ready_q     <= ready_d;
            fill_bank_q <= fill_bank_d;
            disp_bank_q <= disp_bank_d;
            last_y_q    <= last_y_d;
            underrun_q  <= underrun_d;
            pix_q       <= pix_d;
        end
    end
endmodule

// File: tb/tb_video_line_prefetcher.sv
// Directed bench for video_line_prefetcher; the memory model returns each word's own address as data.
// Build with READER_TEST_PATTERN_EN to exercise the colour-bar mode instead of the SDRAM path.
module tb_video_line_prefetcher;
    logic clk;
    logic rst;
    int checks = 0;
    int errors = 0;

    video_line_prefetcher_if #(.ADDR_W(20)) bus ();

    video_line_prefetcher #(
        .H_PIXELS(640), .V_LINES(380), .BURST_LEN(8), .ADDR_W(20), .BASE_ADDR(0)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: remembers each accepted burst and supplies address-valued words.
    logic [19:0] base_m;
    int          idx_m;
    int          rem_m;
    int          words_m;
    logic [19:0] acc_q[$];
    int          accw_q[$];

    assign bus.iMem_Data = 30'(base_m) + 30'(idx_m);

    always @(posedge clk) begin
        if (rst) begin
            base_m <= '0;
            idx_m  <= 0;
            rem_m  <= 0;
        end else begin
            if (bus.iMem_Valid && rem_m > 0) begin
                idx_m   <= idx_m + 1;
                rem_m   <= rem_m - 1;
                words_m <= words_m + 1;
            end
            if (bus.oMem_Req && bus.iMem_Ack) begin
                base_m <= bus.oMem_Addr;
                idx_m  <= 0;
                rem_m  <= 8;
                acc_q.push_back(bus.oMem_Addr);
                accw_q.push_back(words_m);
            end
        end
    end

    task automatic wait_acc(input int n, input int budget, output bit ok);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (acc_q.size() >= n);
    endtask

    task automatic clear_acc();
        acc_q.delete();
        accw_q.delete();
    endtask

    task automatic pulse_frame_start();
        bus.iFrame_Start = 1'b1;
        @(negedge clk);
        bus.iFrame_Start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.iFrame_Start = 1'b0;
        bus.iRead_En = 1'b0;
        bus.iRead_X = '0;
        bus.iRead_Y = '0;
        bus.iMem_Ack = 1'b0;
        bus.iMem_Valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_acc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iFrame_Start = 1'b0;
        bus.iRead_En = 1'b0;
        bus.iRead_X = '0;
        bus.iRead_Y = '0;
        bus.iMem_Ack = 1'b0;
        bus.iMem_Valid = 1'b0;
        words_m = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.oVideo_R !== 10'd0) begin errors++; $display("FAIL reset_R: got %0h want 0", bus.oVideo_R); end
        checks++; if (bus.oVideo_G !== 10'd0) begin errors++; $display("FAIL reset_G: got %0h want 0", bus.oVideo_G); end
        checks++; if (bus.oVideo_B !== 10'd0) begin errors++; $display("FAIL reset_B: got %0h want 0", bus.oVideo_B); end
        checks++; if (bus.oMem_Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.oMem_Req); end
        checks++; if (bus.oMem_Addr !== 20'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.oMem_Addr); end
        checks++; if (bus.oUnderrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", bus.oUnderrun); end
        rst = 1'b0;
        @(negedge clk);
        clear_acc();
    endtask

`ifndef READER_TEST_PATTERN_EN
    task automatic test_frame_fetch();
        bit ok;
        int bad = -1;
        clear_acc();
        bus.iMem_Ack = 1'b1;
        bus.iMem_Valid = 1'b1;
        pulse_frame_start();
        wait_acc(80, 2000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok || acc_q.size() != 80) begin errors++; $display("FAIL frame_burst_count: got %0d want 80", acc_q.size()); end
        foreach (acc_q[i]) if (acc_q[i] !== 20'(i * 8) && bad < 0) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL frame_burst_addr: burst %0d got %0h want %0h", bad, acc_q[bad], bad * 8); end
        checks++; if (bus.oMem_Req !== 1'b0) begin errors++; $display("FAIL frame_idle_req: got %b want 0", bus.oMem_Req); end
    endtask

    task automatic test_pixel_read();
        bit ok;
        clear_acc();
        bus.iRead_En = 1'b1; bus.iRead_Y = 10'd0; bus.iRead_X = 10'd0;
        @(negedge clk);
        checks++; if (bus.oVideo_B !== 10'd0) begin errors++; $display("FAIL pix_y0_x0_B: got %0h want 0", bus.oVideo_B); end
        bus.iRead_X = 10'd5;
        @(negedge clk);
        checks++; if ({bus.oVideo_R, bus.oVideo_G, bus.oVideo_B} !== {10'd0, 10'd0, 10'd5}) begin
            errors++; $display("FAIL pix_y0_x5: got R%0h G%0h B%0h want R0 G0 B5", bus.oVideo_R, bus.oVideo_G, bus.oVideo_B); end
        bus.iRead_X = 10'd639;
        @(negedge clk);
        checks++; if (bus.oVideo_B !== 10'd639 || bus.oVideo_G !== 10'd0) begin
            errors++; $display("FAIL pix_y0_x639: got G%0h B%0h want G0 B27f", bus.oVideo_G, bus.oVideo_B); end
        bus.iRead_En = 1'b0;
        @(negedge clk);
        checks++; if (bus.oVideo_B !== 10'd0) begin errors++; $display("FAIL pix_disabled: got %0h want 0", bus.oVideo_B); end
        wait_acc(80, 2000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok || acc_q[0] !== 20'd640 || acc_q[79] !== 20'd1272) begin
            errors++; $display("FAIL line1_fetch: ok %b first %0d want 640", ok, ok ? acc_q[0] : 20'd0); end
        clear_acc();
        bus.iRead_En = 1'b1; bus.iRead_Y = 10'd1; bus.iRead_X = 10'd0;
        @(negedge clk);
        checks++; if (bus.oVideo_B !== 10'd640 || bus.oVideo_G !== 10'd0) begin
            errors++; $display("FAIL pix_y1_x0: got G%0h B%0h want G0 B280", bus.oVideo_G, bus.oVideo_B); end
        bus.iRead_X = 10'd639;
        @(negedge clk);
        checks++; if (bus.oVideo_G !== 10'd1 || bus.oVideo_B !== 10'd255) begin
            errors++; $display("FAIL pix_y1_x639: got G%0h B%0h want G1 Bff", bus.oVideo_G, bus.oVideo_B); end
        bus.iRead_En = 1'b0;
        checks++; if (bus.oUnderrun !== 1'b0) begin errors++; $display("FAIL no_underrun: got %b want 0", bus.oUnderrun); end
        wait_acc(80, 2000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok || acc_q[0] !== 20'd1280) begin errors++; $display("FAIL line2_fetch: ok %b want first addr 1280", ok); end
    endtask

    task automatic test_last_line();
        bit ok;
        int req_seen = 0;
        clear_acc();
        bus.iRead_En = 1'b1; bus.iRead_Y = 10'd379; bus.iRead_X = 10'd0;
        @(negedge clk);
        bus.iRead_En = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.oMem_Req) req_seen++;
            @(negedge clk);
        end
        checks++; if (req_seen != 0 || acc_q.size() != 0) begin
            errors++; $display("FAIL last_line_no_req: req cycles %0d accepts %0d want 0", req_seen, acc_q.size()); end
        pulse_frame_start();
        wait_acc(1, 50, ok);
        checks++; if (!ok || acc_q[0] !== 20'd0) begin errors++; $display("FAIL next_frame_addr: ok %b want addr 0", ok); end
        wait_acc(80, 2000, ok);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_underrun();
        bit ok;
        do_reset();
        bus.iMem_Ack = 1'b1;
        bus.iMem_Valid = 1'b1;
        pulse_frame_start();
        wait_acc(80, 2000, ok);
        repeat (20) @(negedge clk);
        bus.iMem_Ack = 1'b0;
        bus.iMem_Valid = 1'b0;
        clear_acc();
        bus.iRead_En = 1'b1; bus.iRead_Y = 10'd0; bus.iRead_X = 10'd0;
        @(negedge clk);
        bus.iRead_En = 1'b0;
        repeat (3000) @(negedge clk);
        checks++; if (bus.oMem_Req !== 1'b1 || bus.oMem_Addr !== 20'd640) begin
            errors++; $display("FAIL held_req: got req %b addr %0d want 1 640", bus.oMem_Req, bus.oMem_Addr); end
        checks++; if (bus.oUnderrun !== 1'b0) begin errors++; $display("FAIL underrun_early: got %b want 0", bus.oUnderrun); end
        bus.iMem_Ack = 1'b1;
        @(negedge clk);
        bus.iMem_Ack = 1'b0;
        bus.iRead_En = 1'b1; bus.iRead_Y = 10'd1; bus.iRead_X = 10'd0;
        @(negedge clk);
        bus.iRead_En = 1'b0;
        checks++; if (bus.oUnderrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b want 1", bus.oUnderrun); end
        bus.iMem_Valid = 1'b1;
        bus.iMem_Ack = 1'b1;
        wait_acc(2, 100, ok);
        checks++; if (!ok || acc_q[1] !== 20'd1280) begin errors++; $display("FAIL underrun_next_addr: ok %b want addr 1280", ok); end
        checks++; if (!ok || accw_q[1] - accw_q[0] != 8) begin
            errors++; $display("FAIL underrun_drain: words %0d want 8", ok ? accw_q[1] - accw_q[0] : -1); end
        checks++; if (bus.oUnderrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b want 1", bus.oUnderrun); end
        repeat (800) @(negedge clk);
    endtask

    task automatic test_frame_abort();
        bit ok;
        do_reset();
        bus.iMem_Ack = 1'b1;
        bus.iMem_Valid = 1'b0;
        pulse_frame_start();
        wait_acc(1, 20, ok);
        bus.iMem_Ack = 1'b0;
        bus.iMem_Valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.iMem_Valid = 1'b0;
        pulse_frame_start();
        bus.iMem_Ack = 1'b1;
        bus.iMem_Valid = 1'b1;
        wait_acc(2, 100, ok);
        checks++; if (!ok || acc_q[1] !== 20'd0) begin errors++; $display("FAIL abort_next_addr: ok %b want addr 0", ok); end
        checks++; if (!ok || accw_q[1] - accw_q[0] != 8) begin
            errors++; $display("FAIL abort_drain: words %0d want 8 (3 kept + 5 discarded)", ok ? accw_q[1] - accw_q[0] : -1); end
        checks++; if (bus.oUnderrun !== 1'b0) begin errors++; $display("FAIL abort_underrun: got %b want 0", bus.oUnderrun); end
    endtask
`else
    task automatic test_pattern();
        int req_seen = 0;
        logic [9:0] xs [5];
        logic [29:0] exp [5];
        xs  = '{10'd80, 10'd159, 10'd0, 10'd639, 10'd320};
        exp = '{{10'h000, 10'h000, 10'h3FF}, {10'h000, 10'h000, 10'h3FF}, {10'h000, 10'h000, 10'h000},
                {10'h3FF, 10'h3FF, 10'h3FF}, {10'h3FF, 10'h000, 10'h000}};
        bus.iMem_Ack = 1'b1;
        pulse_frame_start();
        for (int i = 0; i < 5; i++) begin
            bus.iRead_En = 1'b1; bus.iRead_Y = 10'd7; bus.iRead_X = xs[i];
            @(negedge clk);
            if (bus.oMem_Req) req_seen++;
            checks++; if ({bus.oVideo_R, bus.oVideo_G, bus.oVideo_B} !== exp[i]) begin
                errors++; $display("FAIL bar_x%0d: got %h want %h", xs[i], {bus.oVideo_R, bus.oVideo_G, bus.oVideo_B}, exp[i]); end
        end
        bus.iRead_En = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.oMem_Req) req_seen++;
        end
        checks++; if (req_seen != 0 || bus.oMem_Addr !== 20'd0) begin
            errors++; $display("FAIL pattern_mem_tied: req cycles %0d addr %0h want 0 0", req_seen, bus.oMem_Addr); end
        checks++; if (bus.oUnderrun !== 1'b0) begin errors++; $display("FAIL pattern_underrun: got %b want 0", bus.oUnderrun); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef READER_TEST_PATTERN_EN
        test_pattern();
`else
        test_frame_fetch();
        test_pixel_read();
        test_last_line();
        test_underrun();
        test_frame_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
